prefetch_queue: RTL and testbench

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/rv32i_types.sv | 25 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/prefetch_queue.sv | 159 +++++++++++++++
 tb/tb_prefetch_queue.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the instruction fetch front end: fetch FSM encoding and
// the prefetch queue entry layout.
package rv32i_types;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_t;

    // 65-bit queue entry: first-after-redirect flag, head PC, fetched word.
    typedef struct packed {
        logic        j;
        logic [31:0] pc;
        logic [31:0] data;
    } fq_entry_t;

    // Bit 1 of the PC is only meaningful on the entry that starts a redirect.
    function automatic logic [31:0] entry_pc(input logic [29:0] word_addr,
                                             input logic        pc_lo,
                                             input logic        j);
        return {word_addr, pc_lo & j, 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of fetched words; head is read combinationally from storage
// and a flush empties it in one cycle.
module fetch_fifo
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  fq_entry_t                push_entry,
    output fq_entry_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    fq_entry_t         mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic              push_ok;
    logic              pop_ok;

    always_comb begin
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        empty   = (count == '0);
        full    = (count == FULL_CNT);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: a single-outstanding fetch FSM filling a small
// FIFO, flushed and restarted on redirect.
module prefetch_queue
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        consume,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_rdata,
    output logic [31:0] out_pc,
    output logic        out_j
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    fetch_state_t   state;
    fetch_state_t   state_d;
    logic [29:0]    fetch_word;
    logic [29:0]    fetch_word_d;
    logic [29:0]    req_word;
    logic [29:0]    req_word_d;
    logic           j_pending;
    logic           j_pending_d;
    logic           pc_lo;
    logic           pc_lo_d;
    logic           resp_fire;
    logic           push;
    logic           pop;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  count_post;
    logic           fifo_empty;
    logic           fifo_full;
    fq_entry_t      push_entry;
    fq_entry_t      head;
    logic           unused_pc0;

    assign unused_pc0 = redirect_pc[0];

    // Redirect wins over both the push and the consume of the same cycle.
    always_comb begin
        resp_fire = (state == FS_REQ) && imem_resp;
        push      = resp_fire && !redirect;
        pop       = consume && !fifo_empty && !redirect;

        count_post = fifo_count;
        if (redirect) begin
            count_post = '0;
        end else if (push && !pop) begin
            count_post = fifo_count + 1'b1;
        end else if (pop && !push) begin
            count_post = fifo_count - 1'b1;
        end

        push_entry.j    = j_pending;
        push_entry.pc   = entry_pc(fetch_word, pc_lo, j_pending);
        push_entry.data = imem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FS_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            FS_IDLE: begin
                state_d = fifo_full ? FS_IDLE : FS_REQ;
            end
            FS_REQ: begin
                if (redirect) begin
                    state_d = imem_resp ? FS_REQ : FS_DROP;
                end else if (imem_resp) begin
                    state_d = (count_post < DEPTH_CNT) ? FS_REQ : FS_IDLE;
                end
            end
            FS_DROP: begin
                if (imem_resp) begin
                    state_d = FS_REQ;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    // req_word is what the memory sees; it only moves when a fresh request
    // starts, so an abandoned read in FS_DROP keeps its original address.
    always_comb begin
        fetch_word_d = fetch_word;
        j_pending_d  = j_pending;
        pc_lo_d      = pc_lo;
        if (redirect) begin
            fetch_word_d = redirect_pc[31:2];
            j_pending_d  = 1'b1;
            pc_lo_d      = redirect_pc[1];
        end else if (push) begin
            fetch_word_d = fetch_word + 30'd1;
            j_pending_d  = 1'b0;
        end

        req_word_d = req_word;
        if (state_d == FS_REQ && (state != FS_REQ || imem_resp)) begin
            req_word_d = fetch_word_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_word <= RESET_PC[31:2];
            req_word   <= RESET_PC[31:2];
            j_pending  <= 1'b1;
            pc_lo      <= 1'b0;
        end else begin
            fetch_word <= fetch_word_d;
            req_word   <= req_word_d;
            j_pending  <= j_pending_d;
            pc_lo      <= pc_lo_d;
        end
    end

    always_comb begin
        imem_read    = (state == FS_REQ) || (state == FS_DROP);
        imem_address = {req_word, 2'b00};
        out_valid    = !fifo_empty;
        out_rdata    = head.data;
        out_pc       = head.pc;
        out_j        = head.j;
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (push),
        .pop        (pop),
        .push_entry (push_entry),
        .head       (head),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: fill, refill, redirect during a read,
// redirect with response, push/consume wrap, reset mid-request.
module tb_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        consume = 1'b0;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic [31:0] out_rdata;
    logic [31:0] out_pc;
    logic        out_j;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0060)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .consume      (consume),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .out_valid    (out_valid),
        .out_rdata    (out_rdata),
        .out_pc       (out_pc),
        .out_j        (out_j)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    // One clock: inputs set before the call are seen at the edge, then cleared.
    task automatic tick();
        @(posedge clk);
        #1;
        consume   = 1'b0;
        redirect  = 1'b0;
        imem_resp = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        consume = 1'b0; redirect = 1'b0; imem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (imem_read !== 1'b0) begin failures++; $display("FAIL reset_read got=%b exp=0", imem_read); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (imem_read !== 1'b0) begin failures++; $display("FAIL release_read got=%b exp=0", imem_read); end
        tick();
        checks++; if (imem_read !== 1'b1) begin failures++; $display("FAIL first_read got=%b exp=1", imem_read); end
        checks++; if (imem_address !== 32'h60) begin failures++; $display("FAIL first_addr got=%h exp=00000060", imem_address); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            imem_resp = 1'b1;
            imem_rdata = word_at(32'h60 + 32'(4 * i));
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fill_valid[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (out_pc !== 32'h60 || out_j !== 1'b1) begin failures++; $display("FAIL fill_head[%0d] got=%h/%b exp=00000060/1", i, out_pc, out_j); end
            checks++; if (out_rdata !== word_at(32'h60)) begin failures++; $display("FAIL fill_data[%0d] got=%h exp=%h", i, out_rdata, word_at(32'h60)); end
            if (i < 3) begin
                checks++; if (imem_read !== 1'b1 || imem_address !== 32'h64 + 32'(4 * i)) begin failures++; $display("FAIL fill_req[%0d] got=%b/%h exp=1/%h", i, imem_read, imem_address, 32'h64 + 32'(4 * i)); end
            end
        end
        checks++; if (imem_read !== 1'b0) begin failures++; $display("FAIL full_read got=%b exp=0", imem_read); end
    endtask

    task automatic test_consume_refill();
        consume = 1'b1;
        tick();
        checks++; if (imem_read !== 1'b0) begin failures++; $display("FAIL refill_idle got=%b exp=0", imem_read); end
        checks++; if (out_pc !== 32'h64 || out_j !== 1'b0) begin failures++; $display("FAIL second_head got=%h/%b exp=00000064/0", out_pc, out_j); end
        checks++; if (out_rdata !== word_at(32'h64)) begin failures++; $display("FAIL second_data got=%h exp=%h", out_rdata, word_at(32'h64)); end
        tick();
        checks++; if (imem_read !== 1'b1 || imem_address !== 32'h70) begin failures++; $display("FAIL refill_req got=%b/%h exp=1/00000070", imem_read, imem_address); end
        checks++; if (out_pc !== 32'h64) begin failures++; $display("FAIL refill_head got=%h exp=00000064", out_pc); end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        tick();
        imem_resp = 1'b1; imem_rdata = word_at(32'h60);
        tick();
        checks++; if (imem_address !== 32'h64) begin failures++; $display("FAIL drop_pre_addr got=%h exp=00000064", imem_address); end
        tick();
        redirect = 1'b1; redirect_pc = 32'h1002;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drop_flush got=%b exp=0", out_valid); end
        checks++; if (imem_read !== 1'b1 || imem_address !== 32'h64) begin failures++; $display("FAIL drop_hold got=%b/%h exp=1/00000064", imem_read, imem_address); end
        tick();
        tick();
        imem_resp = 1'b1; imem_rdata = word_at(32'h64);
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drop_stale got=%b exp=0", out_valid); end
        checks++; if (imem_read !== 1'b1 || imem_address !== 32'h1000) begin failures++; $display("FAIL drop_newreq got=%b/%h exp=1/00001000", imem_read, imem_address); end
        imem_resp = 1'b1; imem_rdata = word_at(32'h1000);
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1002 || out_j !== 1'b1) begin failures++; $display("FAIL drop_head got=%b/%h/%b exp=1/00001002/1", out_valid, out_pc, out_j); end
        checks++; if (out_rdata !== word_at(32'h1000) || imem_address !== 32'h1004) begin failures++; $display("FAIL drop_data got=%h/%h exp=%h/00001004", out_rdata, imem_address, word_at(32'h1000)); end
        imem_resp = 1'b1; imem_rdata = word_at(32'h1004);
        tick();
        consume = 1'b1;
        tick();
        checks++; if (out_pc !== 32'h1004 || out_j !== 1'b0 || out_rdata !== word_at(32'h1004)) begin failures++; $display("FAIL drop_next got=%h/%b/%h exp=00001004/0/%h", out_pc, out_j, out_rdata, word_at(32'h1004)); end
    endtask

    task automatic test_redirect_with_resp();
        imem_resp = 1'b1; imem_rdata = word_at(32'h1008);
        consume = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_empty got=%b exp=0", out_valid); end
        checks++; if (imem_read !== 1'b1 || imem_address !== 32'h200) begin failures++; $display("FAIL rr_req got=%b/%h exp=1/00000200", imem_read, imem_address); end
        imem_resp = 1'b1; imem_rdata = word_at(32'h200);
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_j !== 1'b1) begin failures++; $display("FAIL rr_head got=%b/%h/%b exp=1/00000200/1", out_valid, out_pc, out_j); end
        checks++; if (out_rdata !== word_at(32'h200) || imem_address !== 32'h204) begin failures++; $display("FAIL rr_data got=%h/%h exp=%h/00000204", out_rdata, imem_address, word_at(32'h200)); end
    endtask

    task automatic test_push_consume_wrap();
        logic [31:0] hpc;
        imem_resp = 1'b1; imem_rdata = word_at(32'h204);
        tick();
        for (int k = 0; k < 10; k++) begin
            hpc = 32'h200 + 32'(4 * k);
            checks++; if (out_valid !== 1'b1 || out_pc !== hpc || out_j !== (k == 0)) begin failures++; $display("FAIL wrap_head[%0d] got=%b/%h/%b exp=1/%h/%b", k, out_valid, out_pc, out_j, hpc, k == 0); end
            checks++; if (out_rdata !== word_at(hpc) || imem_address !== hpc + 32'h8) begin failures++; $display("FAIL wrap_data[%0d] got=%h/%h exp=%h/%h", k, out_rdata, imem_address, word_at(hpc), hpc + 32'h8); end
            imem_resp = 1'b1; imem_rdata = word_at(hpc + 32'h8);
            consume = 1'b1;
            tick();
        end
        checks++; if (out_pc !== 32'h228 || out_rdata !== word_at(32'h228) || imem_address !== 32'h230) begin failures++; $display("FAIL wrap_end got=%h/%h/%h exp=00000228/%h/00000230", out_pc, out_rdata, imem_address, word_at(32'h228)); end
        consume = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h22C || out_j !== 1'b0) begin failures++; $display("FAIL wrap_last got=%b/%h/%b exp=1/0000022c/0", out_valid, out_pc, out_j); end
        consume = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wrap_drained got=%b exp=0", out_valid); end
        consume = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_consume got=%b exp=0", out_valid); end
        imem_resp = 1'b1; imem_rdata = word_at(32'h230);
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h230 || out_j !== 1'b0) begin failures++; $display("FAIL after_empty got=%b/%h/%b exp=1/00000230/0", out_valid, out_pc, out_j); end
        consume = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_pop got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_request();
        rst_n = 1'b0;
        #1;
        checks++; if (imem_read !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL midreset got=%b/%b exp=0/0", imem_read, out_valid); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        imem_resp = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL late_resp got=%b exp=0", out_valid); end
        checks++; if (imem_read !== 1'b1 || imem_address !== 32'h60) begin failures++; $display("FAIL refetch_req got=%b/%h exp=1/00000060", imem_read, imem_address); end
        imem_resp = 1'b1; imem_rdata = word_at(32'h60);
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h60 || out_j !== 1'b1) begin failures++; $display("FAIL refetch_head got=%b/%h/%b exp=1/00000060/1", out_valid, out_pc, out_j); end
        checks++; if (out_rdata !== word_at(32'h60)) begin failures++; $display("FAIL refetch_data got=%h exp=%h", out_rdata, word_at(32'h60)); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_consume_refill();
        test_redirect_drop();
        test_redirect_with_resp();
        test_push_consume_wrap();
        test_reset_mid_request();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
